gf128_reduce: RTL and testbench
===============================

# gf128_reduce

Sequential GF(2^128) reduction stage sitting directly downstream of `mul_128_module` in the GHASH datapath. It accepts the 256-bit carry-less product `mul_128` and reduces it modulo P(x) = x^128 + x^7 + x^2 + x + 1, folding 32 coefficients per cycle. It returns the 128-bit field element over a valid/ready handshake and holds it until consumed. The result feeds the GHASH Y register and, XORed with the next block, the next `mul_128_module` operand.

## Interface
Parameters: none (field polynomial and 32-bit fold width are fixed).
- `clk`  in  1  single clock; all state changes on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `clear`  in  1  synchronous abort; priority over all other inputs
- `prod_valid`  in  1  `prod` holds a product to reduce
- `prod_ready`  out  1  block can accept a product (IDLE only)
- `prod`  in  256  carry-less product; bit i = coefficient of x^i (bit 255 is normally 0 but is reduced correctly if set)
- `res_valid`  out  1  `res` holds a reduced result
- `res_ready`  in  1  consumer accepts `res`
- `res`  out  128  reduced field element; bit i = coefficient of x^i
- `busy`  out  1  high in FOLD or DONE

## Operation
- Internal state: work register W[255:0], 2-bit fold counter `cnt`, state in {IDLE, FOLD, DONE}.
- IDLE: `prod_ready`=1. On `prod_valid`: W<=`prod`, `cnt`<=3, go to FOLD.
- FOLD: chunk c = W[128+32*cnt+31 : 128+32*cnt].
  - W <= (W with chunk c zeroed) XOR ((c * (x^7+x^2+x+1)) << 32*cnt); product is a 39-bit carry-less value.
  - `cnt` decrements each cycle; order is 3, 2, 1, 0.
  - The cnt=3 fold spills into bits 128..134, which the cnt=0 fold removes. After cnt=0, W[255:128] is 0.
  - On the cnt=0 cycle: `res`<=folded W[127:0], go to DONE.
- DONE: `res_valid`=1, `res` stable. On `res_ready`: go to IDLE. Holds indefinitely otherwise.
- `clear` (any state): state<=IDLE, W<=0, `cnt`<=0, `res`<=0, `res_valid`<=0. Any in-flight product or unconsumed result is discarded. A `prod_valid` in the same cycle is not accepted (`prod_ready` is 0 while `clear` is high).
- Arithmetic is pure XOR/AND (GF(2)); no carries anywhere.

## Timing
- Reset values: `prod_ready`=1, `res_valid`=0, `res`=0, `busy`=0, state IDLE, W=0, `cnt`=0.
- Product accepted at edge N: FOLD edges are N+1..N+4. `res_valid` is high after edge N+4.
- Latency: 4 cycles from accept to `res_valid`.
- Throughput: with `res_ready` tied high, result handshake at N+5, IDLE after N+5, next accept at edge N+6. Maximum rate is one product per 6 cycles.
- `prod_ready` is combinational from state and `clear` only; no combinational path from `prod_valid` or `res_ready` to any output.
- `res` changes only on the DONE-entry edge, on `clear`, or on reset.
- `prod` is sampled only on the accept edge and may change freely afterwards.
- Reset asserted mid-FOLD or in DONE returns all outputs to reset values immediately (asynchronously), with no result produced.

## Test plan
- Reset, then `prod`=0x88 (carry-less 10x20) -> `res`=0x88; `res_valid` rises exactly 4 cycles after accept.
- `prod`=1<<128 -> `res`=0x87. Then `prod`=1<<255 -> `res`=128'h8000_0000_0000_0000_0000_0000_0000_2049, exercising the cnt=3 spill.
- Random 128x128 operands through a golden carry-less multiply and bitwise reduce model, 1000 products back-to-back with `res_ready`=1 -> all match, accept spacing 6 cycles.
- Backpressure: hold `res_ready`=0 for 10 cycles in DONE -> `res` and `res_valid` stable, `prod_ready`=0. Release -> IDLE next cycle.
- Pulse `clear` at FOLD cnt=1 -> `busy`=0 next cycle, no `res_valid`. The next product reduces correctly.
- Assert `rst` asynchronously mid-FOLD and in DONE -> outputs go to reset values without waiting for a clock edge, and the block resumes cleanly after deassertion.

Source files
------------

// File: rtl/gf128_reduce.sv
// GHASH reduction stage: folds a 256-bit carry-less product modulo
// x^128 + x^7 + x^2 + x + 1, 32 coefficients per cycle, over valid/ready.
module gf128_reduce (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         prod_valid,
    output logic         prod_ready,
    input  logic [255:0] prod,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [127:0] res,
    output logic         busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FOLD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [255:0]  w_q, w_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [127:0]  res_q, res_d;
    logic [7:0]    chunk_lsb_s;
    logic [6:0]    fold_lsb_s;
    logic [31:0]   chunk_s;
    logic [38:0]   fold_s;
    logic [255:0]  folded_s;

    // x^128 == x^7 + x^2 + x + 1, so a chunk above bit 128 is multiplied by 0x87
    function automatic logic [38:0] mul_by_87(input logic [31:0] c);
        logic [38:0] acc;
        acc = {7'd0, c} ^ {6'd0, c, 1'b0} ^ {5'd0, c, 2'b00} ^ {c, 7'b000_0000};
        return acc;
    endfunction

    assign chunk_lsb_s = {1'b1, cnt_q, 5'd0};
    assign fold_lsb_s  = {cnt_q, 5'd0};
    assign chunk_s     = w_q[chunk_lsb_s +: 32];
    assign fold_s      = mul_by_87(chunk_s);
    assign folded_s    = (w_q & ~({224'd0, 32'hFFFF_FFFF} << chunk_lsb_s))
                       ^ ({217'd0, fold_s} << fold_lsb_s);

    // State, work register, fold counter and result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            w_q     <= 256'd0;
            cnt_q   <= 2'd0;
            res_q   <= 128'd0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (prod_valid) state_d = S_FOLD;
                    else            state_d = S_IDLE;
                end
                S_FOLD: begin
                    if (cnt_q == 2'd0) state_d = S_DONE;
                    else               state_d = S_FOLD;
                end
                S_DONE: begin
                    if (res_ready) state_d = S_IDLE;
                    else           state_d = S_DONE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Datapath next values: load, fold step, result capture
    always_comb begin
        w_d   = w_q;
        cnt_d = cnt_q;
        res_d = res_q;
        if (clear) begin
            w_d   = 256'd0;
            cnt_d = 2'd0;
            res_d = 128'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (prod_valid) begin
                        w_d   = prod;
                        cnt_d = 2'd3;
                    end else begin
                        w_d   = w_q;
                    end
                end
                S_FOLD: begin
                    w_d = folded_s;
                    if (cnt_q == 2'd0) begin
                        cnt_d = 2'd0;
                        res_d = folded_s[127:0];
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
                default: begin
                    w_d = w_q;
                end
            endcase
        end
    end

    // Output decode from state register
    always_comb begin
        prod_ready = (state_q == S_IDLE) && !clear;
        res_valid  = (state_q == S_DONE);
        busy       = (state_q != S_IDLE);
        res        = res_q;
    end

endmodule

// File: tb/tb_gf128_reduce.sv
// Scoreboard bench for gf128_reduce: directed vectors plus golden-model products.
`timescale 1ns/1ps
module tb_gf128_reduce;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clear = 1'b0;
    logic         prod_valid = 1'b0;
    logic         prod_ready;
    logic [255:0] prod = 256'd0;
    logic         res_valid;
    logic         res_ready = 1'b1;
    logic [127:0] res;
    logic         busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_acc = -100;
    logic [127:0] exp_q[$];
    int           acc_q[$];

    gf128_reduce dut (
        .clk(clk), .rst(rst), .clear(clear),
        .prod_valid(prod_valid), .prod_ready(prod_ready), .prod(prod),
        .res_valid(res_valid), .res_ready(res_ready), .res(res), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [255:0] clmul(input logic [127:0] a, input logic [127:0] b);
        logic [255:0] r;
        r = 256'd0;
        for (int i = 0; i < 128; i++)
            if (b[i]) r = r ^ ({128'd0, a} << i);
        return r;
    endfunction

    function automatic logic [127:0] reduce(input logic [255:0] v);
        logic [255:0] r;
        logic [255:0] pl;
        r  = v;
        pl = (256'd1 << 128) | 256'h87;
        for (int i = 255; i >= 128; i--)
            if (r[i]) r = r ^ (pl << (i - 128));
        return r[127:0];
    endfunction

    // Issue one product; returns once it has been accepted (or the bound expires)
    task automatic send(input logic [255:0] p, input logic [127:0] e, input bit chk_gap);
        bit ok;
        int t;
        ok = 1'b0;
        t  = 0;
        prod = p;
        prod_valid = 1'b1;
        while (!ok && t < 50) begin
            @(negedge clk);
            ok = prod_ready;
            @(posedge clk);
            t++;
        end
        #1;
        prod_valid = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=0 required=1");
        end else begin
            exp_q.push_back(e);
            acc_q.push_back(cyc);
            if (chk_gap) check("accept_spacing", 128'(cyc - last_acc), 128'd6);
            last_acc = cyc;
        end
        prod = {8{32'hDEAD_BEEF}};
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((busy || exp_q.size() != 0) && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 100) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout actual=busy required=idle");
        end
    endtask

    // Monitor: latency on res_valid rise, value compare on each handshake
    initial begin
        logic prev_v;
        int a;
        logic [127:0] e;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (res_valid && !prev_v) begin
                    if (acc_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_valid actual=1 required=0");
                    end else begin
                        a = acc_q.pop_front();
                        check("latency", 128'(cyc - a), 128'd4);
                    end
                end
                if (res_valid && res_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_result actual=%h required=none", res);
                    end else begin
                        e = exp_q.pop_front();
                        check("result", res, e);
                    end
                end
            end
            prev_v = rst ? 1'b0 : res_valid;
        end
    end

    initial begin
        logic [127:0] a, b;
        logic [255:0] p;
        logic [127:0] hold;

        #12;
        check("rst_prod_ready", {127'd0, prod_ready}, 128'd1);
        check("rst_res_valid", {127'd0, res_valid}, 128'd0);
        check("rst_busy", {127'd0, busy}, 128'd0);
        check("rst_res", res, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        send(256'h88, 128'h88, 1'b0);
        wait_idle();
        send(256'd1 << 128, 128'h87, 1'b0);
        wait_idle();
        send(256'd1 << 255, 128'h8000_0000_0000_0000_0000_0000_0000_2049, 1'b0);
        wait_idle();
        send({128'd0, {4{32'h0123_4567}}}, {4{32'h0123_4567}}, 1'b0);
        wait_idle();

        // Back-to-back golden-model products with res_ready high
        send(clmul(128'h1, 128'h2), 128'h2, 1'b0);
        for (int i = 0; i < 1000; i++) begin
            a = {$urandom, $urandom, $urandom, $urandom};
            b = {$urandom, $urandom, $urandom, $urandom};
            p = clmul(a, b);
            send(p, reduce(p), 1'b1);
        end
        wait_idle();

        // Backpressure in DONE
        res_ready = 1'b0;
        send(256'd1 << 200, reduce(256'd1 << 200), 1'b0);
        repeat (5) @(posedge clk);
        hold = res;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_res_valid", {127'd0, res_valid}, 128'd1);
            check("bp_prod_ready", {127'd0, prod_ready}, 128'd0);
            check("bp_res_stable", res, reduce(256'd1 << 200));
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_idle", {126'd0, prod_ready, busy}, 128'd2);

        // clear in IDLE blocks prod_ready; clear at FOLD cnt=1 aborts
        clear = 1'b1;
        #1;
        check("clear_prod_ready", {127'd0, prod_ready}, 128'd0);
        @(posedge clk);
        #1;
        clear = 1'b0;
        send(256'd3 << 250, 128'd0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        exp_q.delete();
        acc_q.delete();
        check("clear_busy", {127'd0, busy}, 128'd0);
        check("clear_res_valid", {127'd0, res_valid}, 128'd0);
        check("clear_res", res, 128'd0);
        repeat (6) @(posedge clk);
        #1;
        send(256'd3 << 250, reduce(256'd3 << 250), 1'b0);
        wait_idle();

        // Asynchronous reset mid-FOLD
        send(256'd1 << 160, 128'd0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        exp_q.delete();
        acc_q.delete();
        check("arst_fold_busy", {127'd0, busy}, 128'd0);
        check("arst_fold_ready", {127'd0, prod_ready}, 128'd1);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Asynchronous reset in DONE
        res_ready = 1'b0;
        send(256'd1 << 160, 128'd0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("done_before_rst", {127'd0, res_valid}, 128'd1);
        #1;
        rst = 1'b1;
        #1;
        exp_q.delete();
        acc_q.delete();
        check("arst_done_valid", {127'd0, res_valid}, 128'd0);
        check("arst_done_res", res, 128'd0);
        check("arst_done_busy", {127'd0, busy}, 128'd0);
        #1;
        rst = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        send(256'd1 << 160, reduce(256'd1 << 160), 1'b0);
        wait_idle();

        check("final_queue_empty", 128'(exp_q.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
